braille_decoder: RTL and testbench
==================================

BRAILLE_DECODER -- requirements
Module: braille_decoder

Interface
REQ-001 The module SHALL have parameter ERR_W, default 8, giving the error counter width in bits.
REQ-002 The module SHALL have port vClock, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-003 The module SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port cell_in, input, 6 bits: one Braille cell, where bit k is dot k+1 (bit0 = dot1 ... bit5 = dot6) and 1 means raised.
REQ-005 The module SHALL have port cell_valid, input, 1 bit: cell_in is offered.
REQ-006 The module SHALL have port cell_ready, output, 1 bit: the decoder accepts cell_in this cycle.
REQ-007 The module SHALL have port digit_out, output, 4 bits: the decoded decimal digit, 0..9.
REQ-008 The module SHALL have port digit_valid, output, 1 bit: digit_out holds an undelivered digit.
REQ-009 The module SHALL have port digit_ready, input, 1 bit: the sink takes digit_out this cycle.
REQ-010 The module SHALL have port numeric_mode, output, 1 bit: the FSM is in NUMERIC.
REQ-011 The module SHALL have port err_count, output, ERR_W bits: the count of malformed cells.

Function
REQ-012 A cell transfer SHALL occur on a rising edge with cell_valid=1 and cell_ready=1; a digit transfer SHALL occur on a rising edge with digit_valid=1 and digit_ready=1.
REQ-013 cell_ready SHALL equal (~digit_valid | digit_ready), so a full output register that is being drained accepts a new cell in the same cycle.
REQ-014 The decoder SHALL recognise these cells (hex, dot6..dot1): 1=01, 2=03, 3=09, 4=19, 5=11, 6=0B, 7=1B, 8=13, 9=0A, 0=1A, NUMSIGN=3C, SPACE=00.
REQ-015 The FSM SHALL have two states, ALPHA and NUMERIC, and SHALL reset to ALPHA.
REQ-016 In ALPHA: NUMSIGN SHALL go to NUMERIC; any other accepted cell SHALL be discarded with no output and no error, staying in ALPHA.
REQ-017 In NUMERIC: a digit cell SHALL load digit_out and set digit_valid on the edge of acceptance (latency 1 cycle) and stay in NUMERIC.
REQ-018 In NUMERIC: SPACE SHALL go to ALPHA with no output.
REQ-019 In NUMERIC: a repeated NUMSIGN SHALL stay in NUMERIC with no output and no error.
REQ-020 In NUMERIC: any other cell SHALL be counted as an error and SHALL go to ALPHA with no output.
REQ-021 digit_valid SHALL clear on a digit transfer unless a new digit is loaded on the same edge, in which case it SHALL stay 1 with the new value.
REQ-022 digit_out SHALL hold its value while digit_valid=1 and digit_ready=0.
REQ-023 err_count SHALL increment by exactly 1 per error and SHALL saturate at all-ones, with no wrap-around.
REQ-024 Cells presented while cell_ready=0 SHALL have no effect on the FSM, the outputs or err_count.
REQ-025 numeric_mode SHALL be 1 exactly when the FSM is in NUMERIC.

Reset
REQ-026 While reset_n=0, regardless of vClock, the FSM SHALL be ALPHA and digit_valid=0, digit_out=0, err_count=0 and numeric_mode=0.
REQ-027 Assertion of reset_n mid-stream SHALL discard any pending digit.
REQ-028 The first cell accepted after deassertion SHALL be decoded in ALPHA.

Configuration
REQ-029 With macro BRAILLE_DECODER_ERRCNT_EN defined, err_count SHALL behave per REQ-020 and REQ-023.
REQ-030 Without BRAILLE_DECODER_ERRCNT_EN, err_count SHALL be constant 0 and no counter register SHALL be inferred, while FSM error transitions stay unchanged.

Structure
REQ-031 Package braille_pkg SHALL hold the twelve cell constants of REQ-014 and the ALPHA/NUMERIC state encoding.
REQ-032 Package braille_pkg SHALL be shared with the existing digit-to-cell encoder and the testbench checkers.
REQ-033 Combinational sub-module braille_cell_lut SHALL map cell_in to {is_digit, is_numsign, is_space, digit[3:0]}.
REQ-034 braille_decoder SHALL hold all sequential logic: the FSM, the output register and err_count.

Verification
REQ-035 The bench SHALL apply reset, then NUMSIGN (3C) followed by 01, 13 and 1A with digit_ready=1, and SHALL see digits 1, 8 and 0 on successive cycles with err_count=0.
REQ-036 The bench SHALL send cell 01 in ALPHA and SHALL see no digit_valid, numeric_mode=0 and err_count=0.
REQ-037 The bench SHALL send 3C, then 3F (invalid), then 03, and SHALL see err_count=1, numeric_mode=0 after the 3F and no digit for the 03.
REQ-038 The bench SHALL hold digit_ready=0 after 3C then 09, and SHALL see digit_out=3 held, cell_ready=0, and a subsequent 19 ignored until digit_ready=1.
REQ-039 The bench SHALL drive 300 errors (3C then 3F, repeated) with ERR_W=8, and SHALL see err_count saturate at 255.
REQ-040 The bench SHALL assert reset_n=0 while digit_valid=1, and SHALL see digit_valid and err_count cleared asynchronously before the next rising edge of vClock.

Source files
------------

// File: rtl/braille_pkg.sv
// Shared Braille definitions: cell codes (bit k = dot k+1), decoder state
// encoding and the classification record produced by the cell lookup.
package braille_pkg;

    localparam logic [5:0] CELL_1       = 6'h01;
    localparam logic [5:0] CELL_2       = 6'h03;
    localparam logic [5:0] CELL_3       = 6'h09;
    localparam logic [5:0] CELL_4       = 6'h19;
    localparam logic [5:0] CELL_5       = 6'h11;
    localparam logic [5:0] CELL_6       = 6'h0B;
    localparam logic [5:0] CELL_7       = 6'h1B;
    localparam logic [5:0] CELL_8       = 6'h13;
    localparam logic [5:0] CELL_9       = 6'h0A;
    localparam logic [5:0] CELL_0       = 6'h1A;
    localparam logic [5:0] CELL_NUMSIGN = 6'h3C;
    localparam logic [5:0] CELL_SPACE   = 6'h00;

    typedef enum logic {
        ST_ALPHA   = 1'b0,
        ST_NUMERIC = 1'b1
    } state_e;

    typedef struct packed {
        logic       is_digit;
        logic       is_numsign;
        logic       is_space;
        logic [3:0] digit;
    } cell_class_t;

endpackage

// File: rtl/braille_cell_lut.sv
// Combinational classifier: maps one 6-dot cell to {is_digit, is_numsign,
// is_space, digit}. Unrecognised cells yield all-zero.
module braille_cell_lut
    import braille_pkg::*;
(
    input  logic [5:0]  cell_i,
    output cell_class_t cls_o
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a bit unassigned, which would otherwise infer a latch.
        cls_o = '0;
        case (cell_i)
            CELL_1:       begin cls_o.is_digit = 1'b1; cls_o.digit = 4'd1; end
            CELL_2:       begin cls_o.is_digit = 1'b1; cls_o.digit = 4'd2; end
            CELL_3:       begin cls_o.is_digit = 1'b1; cls_o.digit = 4'd3; end
            CELL_4:       begin cls_o.is_digit = 1'b1; cls_o.digit = 4'd4; end
            CELL_5:       begin cls_o.is_digit = 1'b1; cls_o.digit = 4'd5; end
            CELL_6:       begin cls_o.is_digit = 1'b1; cls_o.digit = 4'd6; end
            CELL_7:       begin cls_o.is_digit = 1'b1; cls_o.digit = 4'd7; end
            CELL_8:       begin cls_o.is_digit = 1'b1; cls_o.digit = 4'd8; end
            CELL_9:       begin cls_o.is_digit = 1'b1; cls_o.digit = 4'd9; end
            CELL_0:       begin cls_o.is_digit = 1'b1; cls_o.digit = 4'd0; end
            CELL_NUMSIGN: cls_o.is_numsign = 1'b1;
            CELL_SPACE:   cls_o.is_space   = 1'b1;
            default:      ;
        endcase
    end

endmodule

// File: rtl/braille_decoder.sv
// Braille numeric decoder: ALPHA/NUMERIC FSM, one-deep digit output register
// with valid/ready handshakes, optional saturating malformed-cell counter
// enabled by macro BRAILLE_DECODER_ERRCNT_EN.
module braille_decoder
    import braille_pkg::*;
#(
    parameter int ERR_W = 8
) (
    input  logic             vClock,
    input  logic             reset_n,
    input  logic [5:0]       cell_in,
    input  logic             cell_valid,
    output logic             cell_ready,
    output logic [3:0]       digit_out,
    output logic             digit_valid,
    input  logic             digit_ready,
    output logic             numeric_mode,
    output logic [ERR_W-1:0] err_count
);

    cell_class_t cls;
    state_e      state_q, state_d;
    logic [3:0]  digit_q, digit_d;
    logic        dvalid_q, dvalid_d;
    logic        cell_accept;
    logic        load_digit;
    logic        cell_err;

    braille_cell_lut u_lut (
        .cell_i (cell_in),
        .cls_o  (cls)
    );

    // A full register that is being drained this cycle can take a new cell.
    assign cell_ready  = ~dvalid_q | digit_ready;
    assign cell_accept = cell_valid & cell_ready;

    always_comb begin
        state_d    = state_q;
        load_digit = 1'b0;
        cell_err   = 1'b0;
        if (cell_accept) begin
            case (state_q)
                ST_ALPHA: begin
                    if (cls.is_numsign) state_d = ST_NUMERIC;
                end
                ST_NUMERIC: begin
                    if (cls.is_digit) begin
                        load_digit = 1'b1;
                    end else if (cls.is_space) begin
                        state_d = ST_ALPHA;
                    end else if (!cls.is_numsign) begin
                        cell_err = 1'b1;
                        state_d  = ST_ALPHA;
                    end
                end
                default: state_d = ST_ALPHA;
            endcase
        end
        dvalid_d = load_digit | (dvalid_q & ~digit_ready);
        digit_d  = load_digit ? cls.digit : digit_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge vClock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_ALPHA;
            digit_q  <= 4'd0;
            dvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            digit_q  <= digit_d;
            dvalid_q <= dvalid_d;
        end
    end

    assign digit_out    = digit_q;
    assign digit_valid  = dvalid_q;
    assign numeric_mode = (state_q == ST_NUMERIC);

`ifdef BRAILLE_DECODER_ERRCNT_EN
    logic [ERR_W-1:0] err_q;

    always_ff @(posedge vClock or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= '0;
        end else if (cell_err && (err_q != {ERR_W{1'b1}})) begin
            err_q <= err_q + ERR_W'(1);
        end
    end

    assign err_count = err_q;
`else
    logic unused_cell_err;
    assign unused_cell_err = cell_err;
    assign err_count       = '0;
`endif

endmodule

// File: tb/tb_braille_decoder.sv
// Directed, scoreboard-based bench for braille_decoder; expected error
// counts follow BRAILLE_DECODER_ERRCNT_EN.
module tb_braille_decoder;

    localparam int ERR_W = 8;
`ifdef BRAILLE_DECODER_ERRCNT_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic             vClock = 1'b0;
    logic             reset_n;
    logic [5:0]       cell_in;
    logic             cell_valid;
    logic             cell_ready;
    logic [3:0]       digit_out;
    logic             digit_valid;
    logic             digit_ready;
    logic             numeric_mode;
    logic [ERR_W-1:0] err_count;

    int         errors = 0;
    int         checks = 0;
    int         model_err = 0;
    logic [3:0] sb[$];

    braille_decoder #(.ERR_W(ERR_W)) dut (
        .vClock       (vClock),
        .reset_n      (reset_n),
        .cell_in      (cell_in),
        .cell_valid   (cell_valid),
        .cell_ready   (cell_ready),
        .digit_out    (digit_out),
        .digit_valid  (digit_valid),
        .digit_ready  (digit_ready),
        .numeric_mode (numeric_mode),
        .err_count    (err_count)
    );

    always #5 vClock = ~vClock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void bump_err();
        if (ERR_ON && model_err < 255) model_err++;
    endfunction

    // Drive a cell and hold it through one rising edge; caller knows it is accepted.
    task automatic send(input logic [5:0] c);
        cell_in    = c;
        cell_valid = 1'b1;
        @(posedge vClock);
        #1;
    endtask

    task automatic idle();
        cell_valid = 1'b0;
        cell_in    = 6'h00;
    endtask

    // A digit transfer happens on the coming edge: compare against the oldest expected digit.
    always @(negedge vClock) begin
        logic [3:0] exp_d;
        if (reset_n && digit_valid && digit_ready) begin
            exp_d = (sb.size() != 0) ? sb.pop_front() : 4'hF;
            check("digit_delivered", 32'(digit_out), 32'(exp_d));
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n     = 1'b0;
        cell_in     = 6'h00;
        cell_valid  = 1'b0;
        digit_ready = 1'b1;
        #2;
        check("rst_digit_valid", 32'(digit_valid), 0);
        check("rst_digit_out", 32'(digit_out), 0);
        check("rst_err_count", 32'(err_count), 0);
        check("rst_numeric", 32'(numeric_mode), 0);
        repeat (2) @(posedge vClock);
        #1 reset_n = 1'b1;
        @(posedge vClock); #1;

        // NUMSIGN then 1, 8, 0 back to back with the sink always ready
        send(6'h3C);
        check("numsign_enter", 32'(numeric_mode), 1);
        sb.push_back(4'd1); send(6'h01);
        check("latency_valid", 32'(digit_valid), 1);
        check("latency_value", 32'(digit_out), 1);
        sb.push_back(4'd8); send(6'h13);
        check("b2b_value", 32'(digit_out), 8);
        sb.push_back(4'd0); send(6'h1A);
        check("b2b_valid", 32'(digit_valid), 1);
        idle();
        @(posedge vClock); #1;
        check("drained", 32'(digit_valid), 0);
        check("no_err_digits", 32'(err_count), 0);

        // Repeated NUMSIGN stays numeric; SPACE returns to ALPHA
        send(6'h3C);
        check("numsign_repeat", 32'(numeric_mode), 1);
        send(6'h00);
        check("space_exit", 32'(numeric_mode), 0);
        check("space_no_digit", 32'(digit_valid), 0);

        // A digit cell in ALPHA is dropped silently
        send(6'h01);
        idle();
        check("alpha_no_digit", 32'(digit_valid), 0);
        check("alpha_mode", 32'(numeric_mode), 0);
        check("alpha_no_err", 32'(err_count), 0);

        // Malformed cell in NUMERIC: error, back to ALPHA, following digit ignored
        send(6'h3C);
        send(6'h3F);
        bump_err();
        check("bad_err_count", 32'(err_count), 32'(model_err));
        check("bad_mode", 32'(numeric_mode), 0);
        send(6'h03);
        idle();
        check("post_err_no_digit", 32'(digit_valid), 0);

        // Back-pressure: digit 3 held, 19 refused until the sink is ready
        digit_ready = 1'b0;
        send(6'h3C);
        sb.push_back(4'd3); send(6'h09);
        cell_in = 6'h19;
        for (int i = 0; i < 3; i++) begin
            @(posedge vClock); #1;
            check("hold_value", 32'(digit_out), 3);
            check("hold_ready", 32'(cell_ready), 0);
        end
        check("hold_valid", 32'(digit_valid), 1);
        sb.push_back(4'd4);
        digit_ready = 1'b1;
        @(posedge vClock); #1;
        idle();
        check("drain_reload_valid", 32'(digit_valid), 1);
        check("drain_reload_value", 32'(digit_out), 4);
        @(posedge vClock); #1;
        check("drain_final", 32'(digit_valid), 0);

        // 300 errors: counter saturates at all-ones
        for (int i = 0; i < 300; i++) begin
            send(6'h3C);
            send(6'h3F);
            bump_err();
            if (i == 253 || i == 254 || i == 299)
                check("sat_err_count", 32'(err_count), 32'(model_err));
        end
        idle();
        check("sat_final_mode", 32'(numeric_mode), 0);

        // Asynchronous reset while a digit is pending
        digit_ready = 1'b0;
        send(6'h3C);
        send(6'h01);
        idle();
        check("pending_before_rst", 32'(digit_valid), 1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(digit_valid), 0);
        check("async_rst_err", 32'(err_count), 0);
        check("async_rst_mode", 32'(numeric_mode), 0);
        check("async_rst_out", 32'(digit_out), 0);
        @(posedge vClock); #1;
        reset_n     = 1'b1;
        digit_ready = 1'b1;

        // First cell after reset is decoded in ALPHA
        send(6'h01);
        check("post_rst_alpha", 32'(digit_valid), 0);
        send(6'h3C);
        sb.push_back(4'd2); send(6'h03);
        idle();
        check("post_rst_digit", 32'(digit_out), 2);
        @(posedge vClock); #1;
        check("sb_empty", 32'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
